// File: rtl/de10_pkg.sv
// rtl/de10_pkg.sv - shared DE10-Lite constants: direction, FSM encoding, board clock
package de10_pkg;

   // Direction encoding on the up input
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Board clock frequency, also the default one-second prescale
   localparam int CLK_HZ = 50_000_000;

   // Counter run state
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a 1-cycle count enable every PRESCALE enabled cycles
module tick_gen #(
   parameter int PRESCALE = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int                  PRE_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(PRESCALE - 1);

   logic [PRE_BITS-1:0] r_pre;
   logic                w_last;

   // Tick is combinational so PRESCALE=1 degenerates to tick=en with no latency
   assign w_last = (r_pre == PRE_LAST);
   assign o_tick = i_en & w_last;

   // Prescale counter: holds its value while disabled so no tick is lost or gained
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pre <= '0;
      end else if (i_clr) begin
         r_pre <= '0;
      end else if (i_en) begin
         r_pre <= w_last ? '0 : r_pre + PRE_BITS'(1);
      end
   end

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N up/down counter with prescaler, one-shot and cascade pulses; optional MOD_COUNTER_LOAD_EN
module mod_counter
   import de10_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = CLK_HZ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             up,
   input  logic             oneshot,
`ifdef MOD_COUNTER_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] din,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   // Terminal value kept in WIDTH bits; the extended copy lets din be compared
   // against MODULUS even when MODULUS equals 2**WIDTH
   localparam logic [WIDTH-1:0] MOD_LAST = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_done;
   state_t           r_state;

   logic             w_tick;
   logic             w_tc;
   logic             w_up;
   logic [WIDTH-1:0] w_start;
   logic             w_load;
   logic [WIDTH-1:0] w_load_val;

`ifdef MOD_COUNTER_LOAD_EN
   // Out-of-range load values saturate at the top of the range
   assign w_load     = load;
   assign w_load_val = ({1'b0, din} >= MOD_EXT) ? MOD_LAST : din;
`else
   assign w_load     = 1'b0;
   assign w_load_val = '0;
`endif

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_en    (en),
      .i_clr   (clr | w_load),
      .o_tick  (w_tick)
   );

   // Terminal and restart values both follow the live direction input
   assign w_up    = (up == DIR_UP);
   assign w_tc    = w_up ? (r_count == MOD_LAST) : (r_count == '0);
   assign w_start = w_up ? '0 : MOD_LAST;

   assign count = r_count;
   assign tick  = w_tick;
   assign tc    = w_tc;
   assign wrap  = r_wrap;
   assign done  = r_done;

   // Counter and RUN/DONE FSM: clr beats load beats tick; wrap is a 1-cycle pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
         r_state <= ST_RUN;
      end else begin
         r_wrap <= 1'b0;
         if (clr) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
         end else if (w_load) begin
            r_count <= w_load_val;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_tick) begin
                     if (w_tc) begin
                        if (oneshot) begin
                           r_state <= ST_DONE;
                           r_done  <= 1'b1;
                        end else begin
                           r_count <= w_start;
                           r_wrap  <= 1'b1;
                        end
                     end else begin
                        r_count <= w_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
                     end
                  end
               end
               ST_DONE: begin
                  if (!oneshot) begin
                     r_state <= ST_RUN;
                     r_done  <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter (WIDTH=4, MODULUS=10, PRESCALE=4)
module tb_mod_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       clr;
   logic       up;
   logic       oneshot;
`ifdef MOD_COUNTER_LOAD_EN
   logic       load;
   logic [3:0] din;
`endif
   logic [3:0] count;
   logic       tick;
   logic       tc;
   logic       wrap;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;
   int n_wait;
   int n_ticks;

   mod_counter #(
      .WIDTH    (4),
      .MODULUS  (10),
      .PRESCALE (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .up      (up),
      .oneshot (oneshot),
`ifdef MOD_COUNTER_LOAD_EN
      .load    (load),
      .din     (din),
`endif
      .count   (count),
      .tick    (tick),
      .tc      (tc),
      .wrap    (wrap),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge, then settle before driving or sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until tick is high (bounded); n returns the edges consumed
   task automatic wait_tick(output int n);
      n = 0;
      while (!tick && n < 16) begin
         step();
         n++;
      end
      if (!tick) check("tick_timeout", 32'(tick), 32'd1);
   endtask

   initial begin
      rst     = 1'b0;
      en      = 1'b0;
      clr     = 1'b0;
      up      = 1'b1;
      oneshot = 1'b0;
`ifdef MOD_COUNTER_LOAD_EN
      load    = 1'b0;
      din     = 4'd0;
`endif
      #2;
      check("rst_count", 32'(count), 32'd0);
      check("rst_tick",  32'(tick),  32'd0);
      check("rst_wrap",  32'(wrap),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_tc_up", 32'(tc),    32'd0);
      up = 1'b0;
      #1;
      check("rst_tc_dn", 32'(tc),    32'd1);
      up = 1'b1;
      step();
      step();

      // 1: up count 0..9,0 with a tick every 4th cycle
      rst = 1'b1;
      en  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         wait_tick(n_wait);
         check("t1_period", 32'(n_wait), 32'd3);
         check("t1_tc", 32'(tc), 32'((k - 1) == 9));
         step();
         check("t1_count", 32'(count), 32'(k % 10));
         check("t1_wrap",  32'(wrap),  32'(k == 10));
         check("t1_tick_low", 32'(tick), 32'd0);
      end

      // 2: down from 0 wraps to 9
      up = 1'b0;
      #1;
      check("t2_tc_at0", 32'(tc), 32'd1);
      wait_tick(n_wait);
      step();
      check("t2_count_9", 32'(count), 32'd9);
      check("t2_wrap",    32'(wrap),  32'd1);
      check("t2_tc_at9",  32'(tc),    32'd0);
      wait_tick(n_wait);
      step();
      check("t2_count_8", 32'(count), 32'd8);
      check("t2_wrap_8",  32'(wrap),  32'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t2_clr", 32'(count), 32'd0);

      // 3: one-shot up stops at 9 with done held until clr
      up      = 1'b1;
      oneshot = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         wait_tick(n_wait);
         step();
         check("t3_count", 32'(count), 32'(k));
         check("t3_wrap",  32'(wrap),  32'd0);
         check("t3_done",  32'(done),  32'd0);
      end
      check("t3_tc", 32'(tc), 32'd1);
      wait_tick(n_wait);
      step();
      check("t3_stop_count", 32'(count), 32'd9);
      check("t3_stop_done",  32'(done),  32'd1);
      check("t3_stop_wrap",  32'(wrap),  32'd0);
      wait_tick(n_wait);
      step();
      check("t3_hold_count", 32'(count), 32'd9);
      check("t3_hold_done",  32'(done),  32'd1);
      clr = 1'b1;
      step();
      clr     = 1'b0;
      oneshot = 1'b0;
      check("t3_clr_count", 32'(count), 32'd0);
      check("t3_clr_done",  32'(done),  32'd0);

      // 4: pause the prescaler mid-period
      step();
      step();
      check("t4_pre_tick", 32'(tick), 32'd0);
      en      = 1'b0;
      n_ticks = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (tick) n_ticks++;
      end
      check("t4_paused_ticks", 32'(n_ticks), 32'd0);
      check("t4_paused_count", 32'(count),   32'd0);
      en = 1'b1;
      #1;
      check("t4_resume_c1", 32'(tick), 32'd0);
      step();
      check("t4_resume_c2", 32'(tick), 32'd1);
      step();
      check("t4_count", 32'(count), 32'd1);

      // 5: clr wins over a tick at count 5, then async reset mid-count
      n_wait = 0;
      for (int i = 0; i < 10; i++) begin
         wait_tick(n_wait);
         if (count == 4'd5) break;
         step();
      end
      check("t5_at5", 32'(count), 32'd5);
      check("t5_tick", 32'(tick), 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t5_clr_count", 32'(count), 32'd0);
      check("t5_clr_wrap",  32'(wrap),  32'd0);
      for (int k = 0; k < 3; k++) begin
         wait_tick(n_wait);
         step();
      end
      check("t5_pre_rst", 32'(count), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check("t5_async_count", 32'(count), 32'd0);
      check("t5_async_done",  32'(done),  32'd0);
      step();
      rst = 1'b1;
      #1;
      check("t5_post_tick", 32'(tick), 32'd0);

`ifdef MOD_COUNTER_LOAD_EN
      // 6: parallel load, clamp, and clr priority
      en   = 1'b0;
      load = 1'b1;
      din  = 4'd7;
      step();
      check("t6_load7", 32'(count), 32'd7);
      din = 4'd12;
      step();
      check("t6_clamp", 32'(count), 32'd9);
      din = 4'd7;
      clr = 1'b1;
      step();
      check("t6_clr_wins", 32'(count), 32'd0);
      clr  = 1'b0;
      load = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
